// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-side bundle for the UART transmit frame generator.
// master: word source (P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale) and
// observer of TX_OUT, Busy, Done; slave: the frame generator itself.
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  Done;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy, Done
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy, Done
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start, DATA_WIDTH data bits LSB first,
// optional parity, stop; each bit held Prescale CLK cycles (0 acts as 1).
// Ports: CLK, RST (async active-low), bus (slave: P_DATA, Data_Valid,
// PAR_EN, PAR_TYP, Prescale in; TX_OUT registered, Busy, Done out).
// Macro UART_TX_TWO_STOP_EN: two stop bits instead of one.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_frame_gen_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [2:0] LAST_STOP = 3'd1;
`else
    localparam logic [2:0] LAST_STOP = 3'd0;
`endif

    state_t                state, state_n;
    logic [5:0]            edge_cnt, edge_n;
    logic [2:0]            bit_cnt, bit_n;
    logic [5:0]            pre_q, pre_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  pen_q, pen_n;
    logic                  par_q, par_n;
    logic                  tx_q, tx_n;
    logic                  edge_last;
    logic                  accept;

    assign accept    = (state == IDLE) && bus.Data_Valid;
    assign edge_last = (edge_cnt == pre_q - 6'd1);

    // Frame configuration is captured only on acceptance
    always_comb begin
        data_n = data_q;
        pre_n  = pre_q;
        pen_n  = pen_q;
        par_n  = par_q;
        if (accept) begin
            data_n = bus.P_DATA;
            pre_n  = (bus.Prescale == 6'd0) ? 6'd1 : bus.Prescale;
            pen_n  = bus.PAR_EN;
            par_n  = (^bus.P_DATA) ^ bus.PAR_TYP;
        end
    end

    always_comb begin
        state_n = state;
        edge_n  = edge_cnt;
        bit_n   = bit_cnt;
        if (state != IDLE) begin
            edge_n = edge_last ? 6'd0 : edge_cnt + 6'd1;
        end
        unique case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    state_n = START;
                    edge_n  = 6'd0;
                    bit_n   = 3'd0;
                end
            end
            START: begin
                if (edge_last) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (edge_last) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n = pen_q ? PARITY : STOP;
                        bit_n   = 3'd0;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (edge_last) begin
                    state_n = STOP;
                    bit_n   = 3'd0;
                end
            end
            STOP: begin
                // bit_cnt doubles as the stop-bit index
                if (edge_last) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_n = IDLE;
                        bit_n   = 3'd0;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                edge_n  = 6'd0;
                bit_n   = 3'd0;
            end
        endcase
    end

    // Line level is decoded from next-state values and registered
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_n[bit_n];
            PARITY:  tx_n = par_n;
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
            bit_cnt  <= 3'd0;
            pre_q    <= 6'd0;
            data_q   <= '0;
            pen_q    <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            edge_cnt <= edge_n;
            bit_cnt  <= bit_n;
            pre_q    <= pre_n;
            data_q   <= data_n;
            pen_q    <= pen_n;
            par_q    <= par_n;
            tx_q     <= tx_n;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = (state != IDLE);
    assign bus.Done   = (state == STOP) && edge_last
                        && (bit_cnt == LAST_STOP);
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: vector table of frames run back-to-back,
// plus ignored-request and mid-frame reset sequences.
module tb_uart_tx_frame_gen;
    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_frame_gen_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame_gen #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        int         len;
    } vec_t;

    typedef struct {
        logic tx;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected line level and Done for every cycle of one frame
    function automatic void model(input logic [7:0] d, input logic pe,
                                  input logic pt, input logic [5:0] ps);
        int   n;
        int   ones;
        logic bits[$];
        n    = (ps == 6'd0) ? 1 : int'(ps);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
        for (int s = 0; s < NSTOP; s++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < n; c++) begin
                exp_t e;
                e.tx   = bits[b];
                e.done = (b == bits.size() - 1) && (c == n - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Called at a negedge while the DUT is idle
    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pt, input logic [5:0] ps);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        model(d, pe, pt, ps);
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = ~d;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
        bus.Prescale   = ps + 6'd7;
    endtask

    task automatic drain(input string tag, input int exp_len,
                         input int inj);
        int   busy_n;
        int   k;
        exp_t e;
        busy_n = 0;
        k      = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            k++;
            chk($sformatf("%s tx c%0d", tag, k), bus.TX_OUT, e.tx);
            chk($sformatf("%s done c%0d", tag, k), bus.Done, e.done);
            if (bus.Busy) busy_n++;
            if (k == inj) begin
                bus.P_DATA     = 8'h12;
                bus.Data_Valid = 1'b1;
            end else begin
                bus.Data_Valid = 1'b0;
            end
        end
        chk($sformatf("%s busy_len", tag), busy_n, exp_len);
        @(negedge CLK);
        chk($sformatf("%s idle busy", tag), bus.Busy, 1'b0);
        chk($sformatf("%s idle tx", tag), bus.TX_OUT, 1'b1);
        chk($sformatf("%s idle done", tag), bus.Done, 1'b0);
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd8, (10 + NSTOP) * 8};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 6'd4, (10 + NSTOP) * 4};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 6'd1, (9 + NSTOP)};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 6'd1, (9 + NSTOP)};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 6'd0, (9 + NSTOP)};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 6'd3, (10 + NSTOP) * 3};
        vecs[6] = '{8'hC3, 1'b0, 1'b1, 6'd2, (9 + NSTOP) * 2};

        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd1;

        repeat (3) @(negedge CLK);
        chk("reset tx", bus.TX_OUT, 1'b1);
        chk("reset busy", bus.Busy, 1'b0);
        chk("reset done", bus.Done, 1'b0);
        RST = 1'b1;
        @(negedge CLK);

        // Each frame starts in the first idle cycle after the previous one
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].ps);
            drain($sformatf("vec%0d", v), vecs[v].len, -1);
        end

        // Request during a frame is dropped
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        drain("ignore", (10 + NSTOP) * 8, 20);
        repeat (4) begin
            @(negedge CLK);
            chk("post-ignore tx", bus.TX_OUT, 1'b1);
            chk("post-ignore busy", bus.Busy, 1'b0);
        end

        // Reset during data bit 3 abandons the frame
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        for (int c = 1; c <= 35; c++) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            chk($sformatf("rst-pre tx c%0d", c), bus.TX_OUT, e.tx);
        end
        RST = 1'b0;
        #1;
        chk("rst tx", bus.TX_OUT, 1'b1);
        chk("rst busy", bus.Busy, 1'b0);
        chk("rst done", bus.Done, 1'b0);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst-rel tx", bus.TX_OUT, 1'b1);
        chk("rst-rel busy", bus.Busy, 1'b0);
        send(8'h96, 1'b1, 1'b1, 6'd2);
        drain("after-rst", (10 + NSTOP) * 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
